goldschmidt_sequencer: RTL and testbench
========================================

Name: goldschmidt_sequencer

Overview:
- Iteration controller for the Goldschmidt divider.
- Time-shares one external 24x24 ArrayMultiplier between the denominator stream (D*F) and the numerator stream (N*F).
- Runs a fixed number of iterations with F = 2 - D, then returns N as the quotient.
- Sits between the divider's operand interface and the shared multiplier instance.

Parameters:
- WIDTH, 24: operand, quotient and multiplier-input width. Fixed point Q1.23, value = x / 2^23.
- ITERATIONS, 5: number of Goldschmidt iterations per division (>=1).
- MUL_LATENCY, 1: cycles from operands presented on mul_a/mul_b to the product being valid on mul_p (>=0).

Ports:
- clock, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a division. Sampled only in IDLE.
- dividend, input, WIDTH: N0, Q1.23. Sampled at the start edge.
- divisor, input, WIDTH: D0, Q1.23, normalized with bit[WIDTH-1]=1. Sampled at the start edge.
- busy, output, 1: high from the cycle after an accepted start until the cycle done is high, inclusive.
- done, output, 1: one-cycle pulse, result valid.
- quotient, output, WIDTH: final N, held until the next done.
- error, output, 1: valid with done. High when the divisor is not normalized.
- mul_a, output, WIDTH: multiplier operand A.
- mul_b, output, WIDTH: multiplier operand B.
- mul_p, input, 2*WIDTH: multiplier product, Q2.46.

Behaviour:
- Reset (async, any state):
  - state=IDLE; busy=0, done=0, error=0.
  - quotient=0, mul_a=0, mul_b=0.
  - Internal N, D, iteration count and the tag pipeline all cleared.
  - An in-flight division is abandoned with no done pulse.
- States: IDLE, ISSUE_D, ISSUE_N, WAIT, FINISH.
- IDLE:
  - On start: latch N=dividend, D=divisor, iter=0.
  - If divisor[WIDTH-1]=0, go to FINISH with the error flag set. Otherwise go to ISSUE_D.
  - start while not in IDLE is ignored. It is not queued.
- F = two's-complement negation of D, modulo 2^WIDTH. This equals 2-D in Q1.23; for D=0x800000, F=0x800000.
- F is computed from the registered D at the start of each iteration and held stable through ISSUE_N.
- ISSUE_D: mul_a=D, mul_b=F. Push tag D into the tag pipeline. Go to ISSUE_N.
- ISSUE_N: mul_a=N, mul_b=F. Push tag N. Go to WAIT.
- mul_a/mul_b are 0 in every other state. The tag pipeline is MUL_LATENCY deep.
- Tagged capture: on the edge ending cycle t+MUL_LATENCY, for an operand issued in cycle t, load mul_p[46:23] into D or N per the tag. The result is truncated, not rounded. Bits [47] and [22:0] are discarded.
- With MUL_LATENCY=0, capture happens at the edge ending the issue cycle itself.
- WAIT: when the N capture occurs:
  - if iter==ITERATIONS-1, go to FINISH;
  - else iter++ and go to ISSUE_D.
- Per-iteration cost is MUL_LATENCY+2 cycles.
- FINISH:
  - quotient = N (normal case), or all ones (error case).
  - done=1 and error updated for exactly one cycle, then IDLE.
  - Accepting a new start requires one cycle in IDLE after done.
- Latency, normal case: done is high in cycle k + ITERATIONS*(MUL_LATENCY+2) + 1 when start is sampled at edge k. With the defaults this is 16 cycles.
- Latency, error case: done is high in cycle k+1.
- Range rules:
  - D in [1,2) converges below 1, so F stays in (0,2) and never wraps.
  - N stays below 2 for any dividend.
  - No saturation logic is required.
- D captures must never overwrite N, and N captures must never overwrite D. The tag guarantees this for any MUL_LATENCY.

Decomposition:
- goldschmidt_pkg:
  - WIDTH and FRAC_BITS=23 constants;
  - ONE = 24'h800000;
  - state enum;
  - a tag enum {TAG_D, TAG_N}.
- One sub-module, gs_tag_pipe: a MUL_LATENCY-deep shift register of {valid, tag} with reset_n. It handles the MUL_LATENCY=0 case as a pass-through.

Test Plan:
- dividend=0xC00000 (1.5), divisor=0x800000 (1.0): F=0x800000 every iteration. Requires done at cycle 16, quotient=0xC00000, error=0.
- dividend=0xC00000, divisor=0xC00000, ITERATIONS=5: D sequence is 0x600000, 0x780000, 0x7F8000, 0x7FFF80, 0x7FFFFF. Requires quotient=0x7FFFFF.
- divisor=0x400000 (not normalized): requires done and error=1 in the cycle after start, quotient=0xFFFFFF, no mul activity.
- Pulse start again during busy, with different operands: requires it to be ignored and the first result unchanged. A start in the cycle after done is accepted.
- Deassert reset_n mid-iteration (after the 2nd ISSUE_N): requires all outputs 0 immediately and no done. A following division of 1.5/1.0 returns 0xC00000.
- Rerun the 1.5/1.0 and 1.5/1.5 cases with MUL_LATENCY=0 and MUL_LATENCY=3: requires identical quotients, with done at cycles 11 and 26 respectively.

Source files
------------

// File: rtl/goldschmidt_pkg.sv
// goldschmidt_pkg: shared constants and enums for the Goldschmidt divider sequencer
package goldschmidt_pkg;
  localparam int WIDTH = 24;
  localparam int FRAC_BITS = 23;
  localparam logic [WIDTH-1:0] ONE = 24'h800000;
  typedef enum logic [2:0] {IDLE, ISSUE_D, ISSUE_N, WAIT, FINISH} state_t;
  typedef enum logic {TAG_D, TAG_N} tag_t;
endpackage

// File: rtl/gs_tag_pipe.sv
// gs_tag_pipe: delays {valid, tag} by the multiplier latency so each product is routed to D or N
module gs_tag_pipe import goldschmidt_pkg::*; #(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  input  tag_t in_tag,
  output logic out_valid,
  output tag_t out_tag
);
  if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_tag = in_tag;
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    tag_t t [DEPTH];
    // shift the issued tag along in lockstep with the multiplier pipeline
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v <= '0;
        for (int i = 0; i < DEPTH; i++) t[i] <= TAG_D;
      end else begin
        v[0] <= in_valid;
        t[0] <= in_tag;
        for (int i = 1; i < DEPTH; i++) begin
          v[i] <= v[i-1];
          t[i] <= t[i-1];
        end
      end
    end
    assign out_valid = v[DEPTH-1];
    assign out_tag = t[DEPTH-1];
  end
endmodule

// File: rtl/goldschmidt_sequencer.sv
// goldschmidt_sequencer: iterates N,D <- N*F, D*F with F = 2-D on one shared multiplier
module goldschmidt_sequencer #(
  parameter int WIDTH = goldschmidt_pkg::WIDTH,
  parameter int ITERATIONS = 5,
  parameter int MUL_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic               error,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p
);
  import goldschmidt_pkg::*;
  localparam int IW = ITERATIONS > 1 ? $clog2(ITERATIONS) : 1;
  localparam int FB = WIDTH - 1;
  state_t state;
  logic [WIDTH-1:0] n, d, f_q, f_now, prod;
  logic [IW-1:0] iter;
  logic push, cap_valid, cap_d, cap_n, last, unused_p;
  tag_t push_tag, cap_tag;
  // F is held in f_q after ISSUE_D because a zero-latency D capture changes d before ISSUE_N
  always_comb begin
    f_now = -d;
    push = state == ISSUE_D || state == ISSUE_N;
    push_tag = state == ISSUE_N ? TAG_N : TAG_D;
    mul_a = state == ISSUE_D ? d : state == ISSUE_N ? n : '0;
    mul_b = state == ISSUE_D ? f_now : state == ISSUE_N ? f_q : '0;
    prod = mul_p[FB+WIDTH-1:FB];
    cap_d = cap_valid && cap_tag == TAG_D;
    cap_n = cap_valid && cap_tag == TAG_N;
    last = iter == IW'(ITERATIONS - 1);
    unused_p = ^{mul_p[2*WIDTH-1], mul_p[FB-1:0]};
  end
  gs_tag_pipe #(.DEPTH(MUL_LATENCY)) u_tag_pipe (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(push),
    .in_tag(push_tag),
    .out_valid(cap_valid),
    .out_tag(cap_tag)
  );
  // iteration FSM with tagged product capture; a start load takes priority over captures
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      n <= '0;
      d <= '0;
      f_q <= '0;
      iter <= '0;
      quotient <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      if (cap_d) d <= prod;
      if (cap_n) n <= prod;
      case (state)
        IDLE: if (start) begin
          n <= dividend;
          d <= divisor;
          iter <= '0;
          busy <= 1'b1;
          if (!divisor[WIDTH-1]) begin
            state <= FINISH;
            done <= 1'b1;
            error <= 1'b1;
            quotient <= '1;
          end else state <= ISSUE_D;
        end
        ISSUE_D: begin
          f_q <= f_now;
          state <= ISSUE_N;
        end
        ISSUE_N, WAIT: if (cap_n) begin
          if (last) begin
            state <= FINISH;
            done <= 1'b1;
            error <= 1'b0;
            quotient <= prod;
          end else begin
            iter <= iter + 1'b1;
            state <= ISSUE_D;
          end
        end else state <= WAIT;
        FINISH: begin
          done <= 1'b0;
          error <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_goldschmidt_sequencer.sv
// tb_goldschmidt_sequencer: three DUTs at multiplier latencies 1, 0, 3 checked against an arithmetic model
module tb_goldschmidt_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [2:0] start = '0;
  logic [2:0][23:0] dividend = '0;
  logic [2:0][23:0] divisor = '0;
  logic [2:0] busy, done, error;
  logic [2:0][23:0] quotient, mul_a, mul_b;
  logic [2:0][47:0] mul_p;
  int tests_run = 0;
  int fails = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? 1 : g == 1 ? 0 : 3;
    logic [47:0] pp [3];
    always @(posedge clock) begin
      pp[0] <= 48'(mul_a[g]) * 48'(mul_b[g]);
      pp[1] <= pp[0];
      pp[2] <= pp[1];
    end
    assign mul_p[g] = L == 0 ? 48'(mul_a[g]) * 48'(mul_b[g]) : pp[L == 0 ? 0 : L - 1];
    goldschmidt_sequencer #(.WIDTH(24), .ITERATIONS(5), .MUL_LATENCY(L)) dut (
      .clock(clock), .reset_n(reset_n), .start(start[g]),
      .dividend(dividend[g]), .divisor(divisor[g]),
      .busy(busy[g]), .done(done[g]), .quotient(quotient[g]), .error(error[g]),
      .mul_a(mul_a[g]), .mul_b(mul_b[g]), .mul_p(mul_p[g])
    );
  end

  function automatic int lat_of(input int g);
    return g == 0 ? 1 : g == 1 ? 0 : 3;
  endfunction

  function automatic int exp_lat(input int g, input logic e);
    return e ? 1 : 5 * (lat_of(g) + 2) + 1;
  endfunction

  // Reference: five rounds of F = 2 - D (mod 2^24), N,D scaled by F, truncated back to Q1.23
  function automatic logic [23:0] model_q(input logic [23:0] nv, input logic [23:0] dv, output logic e);
    logic [23:0] nn, dd, f;
    e = !dv[23];
    if (e) return 24'hFFFFFF;
    nn = nv;
    dd = dv;
    for (int i = 0; i < 5; i++) begin
      f = 24'(25'd16777216 - 25'(dd));
      dd = 24'((48'(dd) * 48'(f)) >> 23);
      nn = 24'((48'(nn) * 48'(f)) >> 23);
    end
    return nn;
  endfunction

  task automatic do_div(input int g, input logic [23:0] nv, input logic [23:0] dv, input int icyc,
                        output logic [23:0] q, output logic e, output int lat,
                        output logic busy_ok, output logic mul_idle);
    @(negedge clock);
    start[g] = 1'b1;
    dividend[g] = nv;
    divisor[g] = dv;
    @(negedge clock);
    start[g] = 1'b0;
    dividend[g] = 24'($urandom);
    divisor[g] = 24'($urandom);
    lat = -1;
    busy_ok = 1'b1;
    mul_idle = 1'b1;
    q = 'x;
    e = 1'bx;
    for (int c = 1; c <= 200; c++) begin
      if (c > 1) @(negedge clock);
      start[g] = c == icyc;
      if (c == icyc) begin
        dividend[g] = 24'($urandom);
        divisor[g] = 24'h800000 | 24'($urandom);
      end
      if (!busy[g]) busy_ok = 1'b0;
      if (mul_a[g] != 0 || mul_b[g] != 0) mul_idle = 1'b0;
      if (done[g]) begin
        lat = c;
        q = quotient[g];
        e = error[g];
        break;
      end
    end
    start[g] = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      tests_run++;
      if ({busy[g], done[g], error[g], quotient[g], mul_a[g], mul_b[g]} !== '0) begin
        fails++;
        $display("FAIL reset g=%0d got busy=%b done=%b err=%b q=%h a=%h b=%h want all 0",
                 g, busy[g], done[g], error[g], quotient[g], mul_a[g], mul_b[g]);
      end
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_checked(input int g, input logic [23:0] nv, input logic [23:0] dv, input int icyc, input string name);
    logic [23:0] q, eq;
    logic e, ee, bok, midle;
    int lat;
    eq = model_q(nv, dv, ee);
    do_div(g, nv, dv, icyc, q, e, lat, bok, midle);
    tests_run++;
    if (q !== eq || e !== ee || lat != exp_lat(g, ee) || !bok) begin
      fails++;
      $display("FAIL %s g=%0d n=%h d=%h got q=%h err=%b lat=%0d busy_ok=%b want q=%h err=%b lat=%0d busy_ok=1",
               name, g, nv, dv, q, e, lat, bok, eq, ee, exp_lat(g, ee));
    end
    if (ee) begin
      tests_run++;
      if (!midle) begin
        fails++;
        $display("FAIL %s_mul_idle g=%0d got mul activity want none", name, g);
      end
    end
  endtask

  task automatic test_directed;
    for (int g = 0; g < 3; g++) begin
      run_checked(g, 24'hC00000, 24'h800000, 0, "div_1p5_1p0");
      @(negedge clock);
      tests_run++;
      if (done[g] !== 1'b0 || busy[g] !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse g=%0d got done=%b busy=%b want 0 0", g, done[g], busy[g]);
      end
      run_checked(g, 24'hC00000, 24'hC00000, 0, "div_1p5_1p5");
    end
  endtask

  task automatic test_error;
    for (int g = 0; g < 3; g++) run_checked(g, 24'($urandom), 24'h400000, 0, "not_normalized");
  endtask

  task automatic test_random;
    logic [23:0] dv;
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 15; i++) begin
        dv = 24'($urandom);
        if ($urandom_range(7) != 0) dv[23] = 1'b1;
        run_checked(g, 24'($urandom), dv, 0, "random");
      end
  endtask

  task automatic test_ignore_start;
    run_checked(0, 24'hC00000, 24'hC00000, 1, "ignore_start_c1");
    run_checked(0, 24'hC00000, 24'hC00000, 8, "ignore_start_c8");
    run_checked(0, 24'hC00000, 24'h800000, 0, "back_to_back");
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b1;
      dividend[g] = 24'hC00000;
      divisor[g] = 24'hC00000;
    end
    @(negedge clock);
    start = '0;
    repeat (7) @(negedge clock);
    tests_run++;
    if (busy !== 3'b111) begin
      fails++;
      $display("FAIL mid_busy got %b want 111", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      tests_run++;
      if ({busy[g], done[g], error[g], quotient[g], mul_a[g], mul_b[g]} !== '0) begin
        fails++;
        $display("FAIL mid_reset g=%0d got busy=%b done=%b err=%b q=%h a=%h b=%h want all 0",
                 g, busy[g], done[g], error[g], quotient[g], mul_a[g], mul_b[g]);
      end
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done != 0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++;
      $display("FAIL abandoned_done got %0d done cycles want 0", seen);
    end
    for (int g = 0; g < 3; g++) run_checked(g, 24'hC00000, 24'h800000, 0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_error;
    test_random;
    test_ignore_start;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
